// File: rtl/dram_ctrl.sv
// dram_ctrl: sequencer for one 16K x 4 multiplexed-address DRAM shared by a
// read-only voice fetch port and a read/write CPU port, with periodic
// RAS-only refresh. Every DRAM strobe and address bit comes from a flop.
// Optional build macro DRAM_ARB_RR_EN: voice/CPU round-robin arbitration
// (default build: fixed priority, voice over CPU).
module dram_ctrl #(
    parameter int T_RCD        = 2,
    parameter int T_CAS        = 2,
    parameter int T_RP         = 2,
    parameter int T_REF        = 3,
    parameter int REF_INTERVAL = 64
) (
    input  logic        clk,
    input  logic        nRESET,
    input  logic        voice_req,
    input  logic [13:0] voice_addr,
    output logic        voice_ack,
    output logic [3:0]  voice_rdata,
    input  logic        cpu_req,
    input  logic        cpu_we,
    input  logic [13:0] cpu_addr,
    input  logic [3:0]  cpu_wdata,
    output logic        cpu_ack,
    output logic [3:0]  cpu_rdata,
    output logic        nRAS,
    output logic        nCAS,
    output logic        nWE,
    output logic [7:0]  A,
    output logic [3:0]  dq_out,
    output logic        dq_oe,
    input  logic [3:0]  dq_in
);
    localparam int TW = $clog2(REF_INTERVAL);

    localparam logic [2:0] S_IDLE = 3'd0;
    localparam logic [2:0] S_RAS  = 3'd1;
    localparam logic [2:0] S_COL  = 3'd2;
    localparam logic [2:0] S_CAS  = 3'd3;
    localparam logic [2:0] S_REF  = 3'd4;
    localparam logic [2:0] S_PRE  = 3'd5;

    logic [2:0]    state_q, state_d;
    logic [7:0]    cnt_q, cnt_d;
    logic [TW-1:0] tmr_q, tmr_d;
    logic          refp_q, refp_d;
    logic [7:0]    rrow_q, rrow_d;
    logic          own_q, own_d;      // 1 = CPU owns the current access
    logic          we_q, we_d;
    logic [3:0]    wdata_q, wdata_d;
    logic [13:0]   addr_q, addr_d;
    logic          nras_q, nras_d, ncas_q, ncas_d, nwe_q, nwe_d;
    logic [7:0]    a_q, a_d;
    logic [3:0]    dqo_q, dqo_d;
    logic          dqoe_q, dqoe_d;
    logic          vack_q, vack_d, cack_q, cack_d;
    logic [3:0]    vrd_q, vrd_d, crd_q, crd_d;
    logic          enter_ref;
    logic          pick_cpu;
    logic [13:0]   gnt_addr;
`ifdef DRAM_ARB_RR_EN
    logic          last_q, last_d;    // 1 = CPU won the last port grant

    // Round-robin: on a tie, the port that did not win last time goes first
    assign pick_cpu = cpu_req & (~voice_req | ~last_q);
`else
    // Fixed priority: voice always beats the CPU
    assign pick_cpu = cpu_req & ~voice_req;
`endif
    assign gnt_addr = pick_cpu ? cpu_addr : voice_addr;

    // Next-state: refresh timer, arbitration and the access/refresh sequencer
    always_comb begin
        state_d   = state_q;
        cnt_d     = cnt_q;
        rrow_d    = rrow_q;
        own_d     = own_q;
        we_d      = we_q;
        wdata_d   = wdata_q;
        addr_d    = addr_q;
        nras_d    = nras_q;
        ncas_d    = ncas_q;
        nwe_d     = nwe_q;
        a_d       = a_q;
        dqo_d     = dqo_q;
        dqoe_d    = dqoe_q;
        vack_d    = 1'b0;
        cack_d    = 1'b0;
        vrd_d     = vrd_q;
        crd_d     = crd_q;
        enter_ref = 1'b0;
`ifdef DRAM_ARB_RR_EN
        last_d    = last_q;
`endif
        tmr_d = (tmr_q == '0) ? TW'(REF_INTERVAL - 1) : tmr_q - TW'(1);

        case (state_q)
            S_IDLE: begin
                if (refp_q) begin
                    enter_ref = 1'b1;
                    a_d       = rrow_q;
                    nras_d    = 1'b0;
                    cnt_d     = 8'(T_REF - 1);
                    state_d   = S_REF;
                end else if (voice_req || cpu_req) begin
                    own_d   = pick_cpu;
                    addr_d  = gnt_addr;
                    we_d    = pick_cpu & cpu_we;
                    wdata_d = cpu_wdata;
                    a_d     = gnt_addr[7:0];
                    nras_d  = 1'b0;
                    cnt_d   = 8'(T_RCD - 1);
                    state_d = S_RAS;
`ifdef DRAM_ARB_RR_EN
                    last_d  = pick_cpu;
`endif
                end
            end
            S_RAS: begin
                if (cnt_q == 8'd0) begin
                    // Early write: nWE and data go out one cycle before nCAS
                    a_d     = {1'b0, addr_q[13:8], 1'b0};
                    nwe_d   = ~we_q;
                    dqoe_d  = we_q;
                    if (we_q) dqo_d = wdata_q;
                    state_d = S_COL;
                end else begin
                    cnt_d = cnt_q - 8'd1;
                end
            end
            S_COL: begin
                ncas_d  = 1'b0;
                cnt_d   = 8'(T_CAS - 1);
                state_d = S_CAS;
            end
            S_CAS: begin
                if (cnt_q == 8'd0) begin
                    if (!we_q) begin
                        if (own_q) crd_d = dq_in;
                        else       vrd_d = dq_in;
                    end
                    cack_d  = own_q;
                    vack_d  = ~own_q;
                    nras_d  = 1'b1;
                    ncas_d  = 1'b1;
                    nwe_d   = 1'b1;
                    dqoe_d  = 1'b0;
                    cnt_d   = 8'(T_RP - 1);
                    state_d = S_PRE;
                end else begin
                    cnt_d = cnt_q - 8'd1;
                end
            end
            S_REF: begin
                if (cnt_q == 8'd0) begin
                    nras_d  = 1'b1;
                    rrow_d  = rrow_q + 8'd1;
                    cnt_d   = 8'(T_RP - 1);
                    state_d = S_PRE;
                end else begin
                    cnt_d = cnt_q - 8'd1;
                end
            end
            S_PRE: begin
                if (cnt_q == 8'd0) state_d = S_IDLE;
                else               cnt_d   = cnt_q - 8'd1;
            end
            default: state_d = S_IDLE;
        endcase

        // A refresh that comes due on the grant edge is a new debt, so set wins
        refp_d = (tmr_q == '0) ? 1'b1 : (enter_ref ? 1'b0 : refp_q);
    end

    // State and strobe registers; reset aborts any cycle in flight
    always_ff @(posedge clk or negedge nRESET) begin
        if (!nRESET) begin
            state_q <= S_IDLE;
            cnt_q   <= '0;
            tmr_q   <= TW'(REF_INTERVAL - 1);
            refp_q  <= 1'b0;
            rrow_q  <= '0;
            own_q   <= 1'b0;
            we_q    <= 1'b0;
            wdata_q <= '0;
            addr_q  <= '0;
            nras_q  <= 1'b1;
            ncas_q  <= 1'b1;
            nwe_q   <= 1'b1;
            a_q     <= '0;
            dqo_q   <= '0;
            dqoe_q  <= 1'b0;
            vack_q  <= 1'b0;
            cack_q  <= 1'b0;
            vrd_q   <= '0;
            crd_q   <= '0;
`ifdef DRAM_ARB_RR_EN
            last_q  <= 1'b1;
`endif
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            tmr_q   <= tmr_d;
            refp_q  <= refp_d;
            rrow_q  <= rrow_d;
            own_q   <= own_d;
            we_q    <= we_d;
            wdata_q <= wdata_d;
            addr_q  <= addr_d;
            nras_q  <= nras_d;
            ncas_q  <= ncas_d;
            nwe_q   <= nwe_d;
            a_q     <= a_d;
            dqo_q   <= dqo_d;
            dqoe_q  <= dqoe_d;
            vack_q  <= vack_d;
            cack_q  <= cack_d;
            vrd_q   <= vrd_d;
            crd_q   <= crd_d;
`ifdef DRAM_ARB_RR_EN
            last_q  <= last_d;
`endif
        end
    end

    assign nRAS        = nras_q;
    assign nCAS        = ncas_q;
    assign nWE         = nwe_q;
    assign A           = a_q;
    assign dq_out      = dqo_q;
    assign dq_oe       = dqoe_q;
    assign voice_ack   = vack_q;
    assign cpu_ack     = cack_q;
    assign voice_rdata = vrd_q;
    assign cpu_rdata   = crd_q;
endmodule

// File: tb/tb_dram_ctrl.sv
// tb_dram_ctrl: directed bench for dram_ctrl with a behavioural 16K x 4 DRAM.
module tb_dram_ctrl;
    logic        clk = 1'b0;
    logic        nRESET;
    logic        voice_req = 1'b0, cpu_req = 1'b0, cpu_we = 1'b0;
    logic [13:0] voice_addr = '0, cpu_addr = '0;
    logic [3:0]  cpu_wdata = '0;
    logic        voice_ack, cpu_ack;
    logic [3:0]  voice_rdata, cpu_rdata;
    logic        nRAS, nCAS, nWE, dq_oe;
    logic [7:0]  A;
    logic [3:0]  dq_out, dq_in;

    int checks = 0;
    int errors = 0;
    bit inv_en = 1'b0;
    logic prev_ncas = 1'b1, prev_nwe = 1'b1;

    logic [3:0] mem [0:16383];
    logic [7:0] mrow = '0;
    logic [5:0] mcol = '0;

    typedef struct {
        bit         voice;
        bit         we;
        logic [13:0] addr;
        logic [3:0]  wdata;
        logic [7:0]  a_row;
        logic [7:0]  a_col;
        logic [3:0]  exp_vrd;
        logic [3:0]  exp_crd;
    } vec_t;
    vec_t tbl [8];

    dram_ctrl dut (
        .clk(clk), .nRESET(nRESET),
        .voice_req(voice_req), .voice_addr(voice_addr), .voice_ack(voice_ack), .voice_rdata(voice_rdata),
        .cpu_req(cpu_req), .cpu_we(cpu_we), .cpu_addr(cpu_addr), .cpu_wdata(cpu_wdata),
        .cpu_ack(cpu_ack), .cpu_rdata(cpu_rdata),
        .nRAS(nRAS), .nCAS(nCAS), .nWE(nWE), .A(A),
        .dq_out(dq_out), .dq_oe(dq_oe), .dq_in(dq_in)
    );

    always #5 clk = ~clk;

    // DRAM model: row on nRAS fall, column (and early write) on nCAS fall
    always @(negedge nRAS) mrow = A;
    always @(negedge nCAS) begin
        mcol = A[6:1];
        if (nWE === 1'b0) mem[{mcol, mrow}] = dq_out;
    end
    assign dq_in = nCAS ? 4'h0 : mem[{mcol, mrow}];

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", nm, act, exp);
        end
    endtask

    // Strobe invariants sampled every cycle
    always @(negedge clk) begin
        if (inv_en) begin
            if (nCAS === 1'b0) chk("inv_cas_needs_ras", nRAS, 0);
            if (prev_ncas === 1'b0 && nCAS === 1'b0) chk("inv_we_stable_in_cas", nWE, prev_nwe);
            prev_ncas = nCAS;
            prev_nwe  = nWE;
        end
    end

    task automatic do_reset();
        @(negedge clk);
        nRESET = 1'b0;
        @(negedge clk);
        nRESET = 1'b1;
    endtask

    task automatic wait_ras_fall(output bit ok);
        logic p;
        p  = nRAS;
        ok = 1'b0;
        for (int n = 0; n < 60; n++) begin
            @(negedge clk);
            if (p === 1'b1 && nRAS === 1'b0) begin
                ok = 1'b1;
                break;
            end
            p = nRAS;
        end
    endtask

    // One access; a refresh that steals the grant is recognised and skipped
    task automatic do_op(input vec_t v, input int idx);
        bit ok, done;
        logic [7:0] row, cola;
        logic cwe, coe, ccas;
        logic [3:0] cdo;
        done = 1'b0;
        if (v.voice) begin
            voice_req = 1'b1; voice_addr = v.addr;
        end else begin
            cpu_req = 1'b1; cpu_we = v.we; cpu_addr = v.addr; cpu_wdata = v.wdata;
        end
        for (int t = 0; t < 4 && !done; t++) begin
            wait_ras_fall(ok);
            if (!ok) begin
                chk($sformatf("op%0d_grant_timeout", idx), nRAS, 0);
                break;
            end
            row = A;
            repeat (2) @(negedge clk);
            cola = A; cwe = nWE; coe = dq_oe; cdo = dq_out; ccas = nCAS;
            @(negedge clk);
            if (nRAS === 1'b1) continue;
            done = 1'b1;
            chk($sformatf("op%0d_row_addr", idx), row, v.a_row);
            chk($sformatf("op%0d_col_addr", idx), cola, v.a_col);
            chk($sformatf("op%0d_col_nwe", idx), cwe, !v.we);
            chk($sformatf("op%0d_col_oe", idx), coe, v.we);
            chk($sformatf("op%0d_col_ncas", idx), ccas, 1);
            if (v.we) chk($sformatf("op%0d_col_dq", idx), cdo, v.wdata);
            @(negedge clk);
            chk($sformatf("op%0d_ack_early", idx), v.voice ? voice_ack : cpu_ack, 0);
            @(negedge clk);
            chk($sformatf("op%0d_ack", idx), v.voice ? voice_ack : cpu_ack, 1);
            chk($sformatf("op%0d_other_ack", idx), v.voice ? cpu_ack : voice_ack, 0);
            chk($sformatf("op%0d_voice_rdata", idx), voice_rdata, v.exp_vrd);
            chk($sformatf("op%0d_cpu_rdata", idx), cpu_rdata, v.exp_crd);
            voice_req = 1'b0; cpu_req = 1'b0;
            @(negedge clk);
            chk($sformatf("op%0d_ack_pulse", idx), v.voice ? voice_ack : cpu_ack, 0);
        end
        if (!done) chk($sformatf("op%0d_served", idx), done, 1);
        voice_req = 1'b0; cpu_req = 1'b0;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    initial begin
        bit ok, done, bad;
        int tv, tc, n_ack;
        int tim [3];
        bit own [3];
        bit [2:0] expo;

        for (int i = 0; i < 16384; i++) mem[i] = 4'h0;
        mem[14'h0123] = 4'h9;

        tbl[0] = '{1'b0, 1'b1, 14'h2A5C, 4'hB, 8'h5C, 8'h54, 4'h0, 4'h0};
        tbl[1] = '{1'b0, 1'b0, 14'h2A5C, 4'h0, 8'h5C, 8'h54, 4'h0, 4'hB};
        tbl[2] = '{1'b1, 1'b0, 14'h2A5C, 4'h0, 8'h5C, 8'h54, 4'hB, 4'hB};
        tbl[3] = '{1'b0, 1'b1, 14'h3FFF, 4'h5, 8'hFF, 8'h7E, 4'hB, 4'hB};
        tbl[4] = '{1'b1, 1'b0, 14'h3FFF, 4'h0, 8'hFF, 8'h7E, 4'h5, 4'hB};
        tbl[5] = '{1'b0, 1'b1, 14'h0000, 4'hA, 8'h00, 8'h00, 4'h5, 4'hB};
        tbl[6] = '{1'b0, 1'b0, 14'h0000, 4'h0, 8'h00, 8'h00, 4'h5, 4'hA};
        tbl[7] = '{1'b0, 1'b0, 14'h3FFF, 4'h0, 8'hFF, 8'h7E, 4'h5, 4'h5};

        // Reset values, then refresh cadence with no requests
        nRESET = 1'b0;
        @(negedge clk);
        chk("rst_nras", nRAS, 1);   chk("rst_ncas", nCAS, 1);  chk("rst_nwe", nWE, 1);
        chk("rst_a", A, 0);         chk("rst_dq_out", dq_out, 0); chk("rst_dq_oe", dq_oe, 0);
        chk("rst_vack", voice_ack, 0); chk("rst_cack", cpu_ack, 0);
        chk("rst_vrd", voice_rdata, 0); chk("rst_crd", cpu_rdata, 0);
        nRESET = 1'b1;
        inv_en = 1'b1;
        bad = 1'b0;
        repeat (64) begin
            @(negedge clk);
            if (nRAS !== 1'b1 || nCAS !== 1'b1) bad = 1'b1;
        end
        chk("ref1_quiet_before", bad, 0);
        @(negedge clk);
        chk("ref1_nras", nRAS, 0);
        chk("ref1_row", A, 8'h00);
        bad = 1'b0;
        repeat (63) begin
            @(negedge clk);
            if (nCAS !== 1'b1) bad = 1'b1;
        end
        chk("ref_ncas_high", bad, 0);
        chk("ref2_not_yet", nRAS, 1);
        @(negedge clk);
        chk("ref2_nras", nRAS, 0);
        chk("ref2_row", A, 8'h01);

        // Table of single accesses
        do_reset();
        for (int i = 0; i < 8; i++) do_op(tbl[i], i);

        // Reset during the CAS phase of a write
        cpu_req = 1'b1; cpu_we = 1'b1; cpu_addr = 14'h1111; cpu_wdata = 4'h7;
        done = 1'b0;
        for (int t = 0; t < 4 && !done; t++) begin
            wait_ras_fall(ok);
            if (!ok) break;
            repeat (3) @(negedge clk);
            if (nRAS === 1'b1) continue;
            done = 1'b1;
        end
        chk("abort_in_cas", nCAS, 0);
        nRESET = 1'b0;
        #1;
        chk("abort_nras", nRAS, 1); chk("abort_ncas", nCAS, 1); chk("abort_nwe", nWE, 1);
        chk("abort_dq_oe", dq_oe, 0); chk("abort_dq_out", dq_out, 0);
        chk("abort_crd", cpu_rdata, 0); chk("abort_vrd", voice_rdata, 0);
        @(negedge clk);
        chk("abort_no_ack", cpu_ack, 0);
        nRESET = 1'b1;
        @(negedge clk);
        chk("reserve_nras", nRAS, 0);
        chk("reserve_row", A, 8'h11);
        repeat (4) @(negedge clk);
        chk("reserve_ack_early", cpu_ack, 0);
        @(negedge clk);
        chk("reserve_ack", cpu_ack, 1);
        cpu_req = 1'b0; cpu_we = 1'b0;
        @(negedge clk);
        do_op('{1'b0, 1'b0, 14'h1111, 4'h0, 8'h11, 8'h22, 4'h0, 4'h7}, 8);

        // Simultaneous requests, voice drops after its ack
        do_reset();
        voice_req = 1'b1; voice_addr = 14'h0001;
        cpu_req = 1'b1; cpu_we = 1'b0; cpu_addr = 14'h0002;
        tv = -1; tc = -1;
        for (int c = 1; c <= 40 && tc < 0; c++) begin
            @(negedge clk);
            if (voice_ack === 1'b1) begin tv = c; voice_req = 1'b0; end
            if (cpu_ack === 1'b1) begin tc = c; cpu_req = 1'b0; end
        end
        voice_req = 1'b0; cpu_req = 1'b0;
        chk("tie_voice_ack_time", tv, 6);
        chk("tie_cpu_ack_time", tc, 14);

        // Both requests held: arbitration order over three grants
        do_reset();
        voice_req = 1'b1; cpu_req = 1'b1;
`ifdef DRAM_ARB_RR_EN
        expo = 3'b010;
`else
        expo = 3'b000;
`endif
        n_ack = 0;
        for (int i = 0; i < 3; i++) begin tim[i] = -1; own[i] = 1'b0; end
        for (int c = 1; c <= 60 && n_ack < 3; c++) begin
            @(negedge clk);
            if (voice_ack === 1'b1) begin tim[n_ack] = c; own[n_ack] = 1'b0; n_ack++; end
            else if (cpu_ack === 1'b1) begin tim[n_ack] = c; own[n_ack] = 1'b1; n_ack++; end
        end
        voice_req = 1'b0; cpu_req = 1'b0;
        chk("held_ack_count", n_ack, 3);
        for (int i = 0; i < 3; i++) begin
            chk($sformatf("held_ack%0d_time", i), tim[i], 6 + 8 * i);
            chk($sformatf("held_ack%0d_owner", i), own[i], expo[i]);
        end

        // Refresh owed and voice request in the same IDLE cycle
        do_reset();
        repeat (64) @(negedge clk);
        voice_req = 1'b1; voice_addr = 14'h0123;
        @(negedge clk);
        chk("refvs_ref_first", nRAS, 0);
        chk("refvs_ref_row", A, 8'h00);
        repeat (5) @(negedge clk);
        chk("refvs_idle_gap", nRAS, 1);
        @(negedge clk);
        chk("refvs_voice_grant", nRAS, 0);
        chk("refvs_voice_row", A, 8'h23);
        repeat (5) @(negedge clk);
        chk("refvs_voice_ack", voice_ack, 1);
        chk("refvs_voice_rdata", voice_rdata, 4'h9);
        voice_req = 1'b0;
        repeat (4) @(negedge clk);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
